tri_fetch_sched: RTL

Clock-domain (clk) sequencer that walks the instance table of raster_mem once per frame and drives its read ports (inst_id_rd, tri_addr_rd, vert_addr_rd).
- For every instance it captures the transform and the vertex/triangle buffer descriptors.
- For every triangle it fetches the index triple, then the three vertices.
- It emits one assembled triangle per valid/ready handshake to the rasterizer front end.

---
 rtl/tri_fetch_sched_pkg.sv | 48 ++++
 rtl/tri_fetch_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_fetch_sched_pkg.sv
// Shared sizes, FSM state type and assembled-triangle bundle for tri_fetch_sched.
package tri_fetch_sched_pkg;

  localparam int MAX_INST = 256;
  localparam int ID_W     = $clog2(MAX_INST);
  localparam int MAX_VERT = 8192;
  localparam int VA_W     = $clog2(MAX_VERT);
  localparam int MAX_TRI  = 8192;
  localparam int TA_W     = $clog2(MAX_TRI);
  localparam int MAX_CNT  = 4096;
  localparam int CNT_W    = $clog2(MAX_CNT);
  localparam int VTX_W    = 108;
  localparam int TRANS_W  = 384;
  localparam int DESC_LAT = 3;
  localparam int WAIT_W   = $clog2(DESC_LAT + 1);

  typedef logic [VTX_W-1:0]   vertex_t;
  typedef logic [TRANS_W-1:0] transform_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INST_ISSUE,
    ST_INST_WAIT,
    ST_TRI_ISSUE,
    ST_TRI_WAIT,
    ST_V_ISSUE,
    ST_V_COLLECT,
    ST_EMIT,
    ST_FINISH
  } tri_fetch_state_t;

  typedef struct packed {
    logic [ID_W-1:0] inst_id;
    transform_t      transform;
    vertex_t [2:0]   v;
  } tri_bundle_t;

  // Pick index k of a packed {i2,i1,i0} triple.
  function automatic logic [CNT_W-1:0] idx_sel(input logic [3*CNT_W-1:0] trip,
                                               input logic [1:0]         k);
    case (k)
      2'd1:    idx_sel = trip[2*CNT_W-1:CNT_W];
      2'd2:    idx_sel = trip[3*CNT_W-1:2*CNT_W];
      default: idx_sel = trip[CNT_W-1:0];
    endcase
  endfunction

endpackage

// File: rtl/tri_fetch_sched.sv
// Frame walker: instance table -> index triples -> vertices -> one triangle per handshake.
// Optional TRI_FETCH_BOUNDS_CHECK_EN drops triangles with out-of-range indices and counts them.
module tri_fetch_sched
  import tri_fetch_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_raster,
  input  logic               start,
  input  logic [ID_W:0]      num_inst,
  output logic               busy,
  output logic               done,
  output logic [ID_W-1:0]    inst_id_rd,
  output logic [TA_W-1:0]    tri_addr_rd,
  output logic [VA_W-1:0]    vert_addr_rd,
  input  logic [VA_W-1:0]    vert_base_in,
  input  logic [CNT_W-1:0]   vert_count_in,
  input  logic [TA_W-1:0]    tri_base_in,
  input  logic [CNT_W-1:0]   tri_count_in,
  input  logic [TRANS_W-1:0] transform_in,
  input  logic [3*CNT_W-1:0] idx_tri_in,
  input  logic [VTX_W-1:0]   vert_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [VTX_W-1:0]   out_v0,
  output logic [VTX_W-1:0]   out_v1,
  output logic [VTX_W-1:0]   out_v2,
  output logic [TRANS_W-1:0] out_transform,
  output logic [ID_W-1:0]    out_inst_id
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
  ,
  output logic [15:0]        oob_count
`endif
);

  tri_fetch_state_t state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, out_valid_q, out_valid_d;
  logic [ID_W-1:0]   inst_rd_q, inst_rd_d;
  logic [TA_W-1:0]   tri_rd_q, tri_rd_d;
  logic [VA_W-1:0]   vert_rd_q, vert_rd_d;
  tri_bundle_t       bundle_q, bundle_d;
  logic [ID_W:0]     num_inst_q, num_inst_d;
  logic [ID_W-1:0]   inst_ctr_q, inst_ctr_d;
  logic [CNT_W-1:0]  tri_ctr_q, tri_ctr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        vidx_q, vidx_d, pend_sel_q, pend_sel_d;
  logic              pend_q, pend_d;

  // Per-instance / per-triangle holding registers; never observed before being loaded.
  logic [VA_W-1:0]    vbase_q, vbase_d;
  logic [TA_W-1:0]    tbase_q, tbase_d;
  logic [CNT_W-1:0]   tcount_q, tcount_d;
  logic [3*CNT_W-1:0] idx_q, idx_d;

`ifdef TRI_FETCH_BOUNDS_CHECK_EN
  logic [CNT_W-1:0] vcount_q, vcount_d;
  logic [15:0]      oob_q, oob_d;
`else
  logic unused_vcount;
  assign unused_vcount = ^vert_count_in;
`endif

  logic          tri_adv, inst_adv;
  logic [CNT_W:0] tri_nxt;
  logic [ID_W:0]  inst_nxt;

  assign tri_nxt  = {1'b0, tri_ctr_q} + (CNT_W+1)'(1);
  assign inst_nxt = {1'b0, inst_ctr_q} + (ID_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    inst_rd_d   = inst_rd_q;
    tri_rd_d    = tri_rd_q;
    vert_rd_d   = vert_rd_q;
    bundle_d    = bundle_q;
    num_inst_d  = num_inst_q;
    inst_ctr_d  = inst_ctr_q;
    tri_ctr_d   = tri_ctr_q;
    wait_d      = wait_q;
    vidx_d      = vidx_q;
    pend_d      = 1'b0;
    pend_sel_d  = pend_sel_q;
    vbase_d     = vbase_q;
    tbase_d     = tbase_q;
    tcount_d    = tcount_q;
    idx_d       = idx_q;
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
    vcount_d    = vcount_q;
    oob_d       = oob_q;
`endif
    tri_adv     = 1'b0;
    inst_adv    = 1'b0;

    // Vertex data returns one cycle after its address was issued.
    if (pend_q) begin
      case (pend_sel_q)
        2'd1:    bundle_d.v[1] = vert_in;
        2'd2:    bundle_d.v[2] = vert_in;
        default: bundle_d.v[0] = vert_in;
      endcase
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
          oob_d = '0;
`endif
          if (num_inst == '0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            num_inst_d = num_inst;
            inst_ctr_d = '0;
            busy_d     = 1'b1;
            state_d    = ST_INST_ISSUE;
          end
        end
      end
      ST_INST_ISSUE: begin
        inst_rd_d = inst_ctr_q;
        wait_d    = WAIT_W'(DESC_LAT - 1);
        state_d   = ST_INST_WAIT;
      end
      ST_INST_WAIT: begin
        if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          vbase_d            = vert_base_in;
          tbase_d            = tri_base_in;
          tcount_d           = tri_count_in;
          bundle_d.transform = transform_in;
          bundle_d.inst_id   = inst_ctr_q;
          tri_ctr_d          = '0;
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
          vcount_d           = vert_count_in;
`endif
          if (tri_count_in == '0) inst_adv = 1'b1;
          else                    state_d  = ST_TRI_ISSUE;
        end
      end
      ST_TRI_ISSUE: begin
        tri_rd_d = tbase_q + TA_W'(tri_ctr_q);
        state_d  = ST_TRI_WAIT;
      end
      ST_TRI_WAIT: begin
        idx_d = idx_tri_in;
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
        if (idx_sel(idx_tri_in, 2'd0) >= vcount_q || idx_sel(idx_tri_in, 2'd1) >= vcount_q ||
            idx_sel(idx_tri_in, 2'd2) >= vcount_q) begin
          if (oob_q != 16'hFFFF) oob_d = oob_q + 16'd1;
          tri_adv = 1'b1;
        end else begin
          vidx_d  = '0;
          state_d = ST_V_ISSUE;
        end
`else
        vidx_d  = '0;
        state_d = ST_V_ISSUE;
`endif
      end
      ST_V_ISSUE: begin
        vert_rd_d  = vbase_q + VA_W'(idx_sel(idx_q, vidx_q));
        pend_d     = 1'b1;
        pend_sel_d = vidx_q;
        vidx_d     = vidx_q + 2'd1;
        if (vidx_q == 2'd2) state_d = ST_V_COLLECT;
      end
      ST_V_COLLECT: begin
        out_valid_d = 1'b1;
        state_d     = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          tri_adv     = 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Advance to next triangle, next instance, or end of frame.
    if (tri_adv) begin
      if (tri_nxt < {1'b0, tcount_q}) begin
        tri_ctr_d = tri_nxt[CNT_W-1:0];
        state_d   = ST_TRI_ISSUE;
      end else begin
        inst_adv = 1'b1;
      end
    end
    if (inst_adv) begin
      if (inst_nxt < num_inst_q) begin
        inst_ctr_d = inst_nxt[ID_W-1:0];
        state_d    = ST_INST_ISSUE;
      end else begin
        state_d = ST_FINISH;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_raster) begin
    if (rst_raster) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      inst_rd_q   <= '0;
      tri_rd_q    <= '0;
      vert_rd_q   <= '0;
      bundle_q    <= '0;
      num_inst_q  <= '0;
      inst_ctr_q  <= '0;
      tri_ctr_q   <= '0;
      wait_q      <= '0;
      vidx_q      <= '0;
      pend_q      <= 1'b0;
      pend_sel_q  <= '0;
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
      oob_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      inst_rd_q   <= inst_rd_d;
      tri_rd_q    <= tri_rd_d;
      vert_rd_q   <= vert_rd_d;
      bundle_q    <= bundle_d;
      num_inst_q  <= num_inst_d;
      inst_ctr_q  <= inst_ctr_d;
      tri_ctr_q   <= tri_ctr_d;
      wait_q      <= wait_d;
      vidx_q      <= vidx_d;
      pend_q      <= pend_d;
      pend_sel_q  <= pend_sel_d;
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
      oob_q       <= oob_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    vbase_q  <= vbase_d;
    tbase_q  <= tbase_d;
    tcount_q <= tcount_d;
    idx_q    <= idx_d;
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
    vcount_q <= vcount_d;
`endif
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign inst_id_rd    = inst_rd_q;
  assign tri_addr_rd   = tri_rd_q;
  assign vert_addr_rd  = vert_rd_q;
  assign out_valid     = out_valid_q;
  assign out_v0        = bundle_q.v[0];
  assign out_v1        = bundle_q.v[1];
  assign out_v2        = bundle_q.v[2];
  assign out_transform = bundle_q.transform;
  assign out_inst_id   = bundle_q.inst_id;
`ifdef TRI_FETCH_BOUNDS_CHECK_EN
  assign oob_count     = oob_q;
`endif

endmodule
